// File: rtl/acorn128_pkg.sv
// Shared types and constants for the ACORN-128 (v3) datapaths.
// Phase enum, step-count constants and the boolean helpers used by the state update.
package acorn128_pkg;

  localparam int STATE_W      = 293;
  localparam int MSG_BITS     = 128;
  localparam int INIT_STEPS   = 1792;
  localparam int KEY_IV_STEPS = 256;
  localparam int PAD_STEPS    = 256;
  localparam int FINAL_STEPS  = 768;
  localparam int TAG_START    = FINAL_STEPS - MSG_BITS;
  localparam int CNT_W        = 11;
  localparam int IDX_W        = $clog2(MSG_BITS);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD,
    AD_PAD,
    CT,
    CT_PAD,
    FINAL,
    DONE
  } phase_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn128_step.sv
// One combinational ACORN-128 state step: feedback-register mixing, keystream bit and shift.
// Keystream does not depend on m, so callers may derive m from ks without a loop.
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] s,
  input  logic               m,
  input  logic               ca,
  input  logic               cb,
  output logic [STATE_W-1:0] s_next,
  output logic               ks
);

  logic [STATE_W-1:0] t;
  logic               f;

  always_comb begin
    t      = s;
    t[290] = s[290] ^ s[235] ^ s[230];
    t[228] = s[228] ^ s[196] ^ s[193];
    t[192] = s[192] ^ s[160] ^ s[154];
    t[153] = s[153] ^ s[111] ^ s[107];
    t[106] = s[106] ^ s[66]  ^ s[61];
    t[60]  = s[60]  ^ s[23]  ^ s[0];
  end

  assign ks     = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
  assign f      = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
  assign s_next = {f ^ m, t[STATE_W-1:1]};

endmodule

// File: rtl/acorn128_decrypt.sv
// ACORN-128 authenticated decryption: FSM, step counter, latched inputs, plaintext/tag shift registers.
// Define ACORN_RELEASE_UNVERIFIED_EN to release plaintext_out even when the tag check fails.
module acorn128_decrypt
  import acorn128_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic [MSG_BITS-1:0] key_in,
  input  logic [MSG_BITS-1:0] iv_in,
  input  logic [MSG_BITS-1:0] associated_data_in,
  input  logic [MSG_BITS-1:0] ciphertext_in,
  input  logic [MSG_BITS-1:0] tag_in,
  output logic [MSG_BITS-1:0] plaintext_out,
  output logic [MSG_BITS-1:0] tag_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                auth_ok_out
);

  phase_t              phase, phase_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [STATE_W-1:0]  state, state_nxt;
  logic [MSG_BITS-1:0] key_r, iv_r, ad_r, ct_r, tag_exp_r, pt_sr;
  logic [MSG_BITS-2:0] tag_sr;
  logic [MSG_BITS-1:0] tag_final;
  logic                m, ca, cb, ks, p;
  logic                last_step, accept, stepping, tag_match;

  assign idx       = cnt[IDX_W-1:0];
  assign accept    = (phase == IDLE) && start_in;
  assign stepping  = (phase != IDLE) && (phase != DONE);
  assign p         = ct_r[idx] ^ ks;
  assign tag_final = {ks, tag_sr};
  assign tag_match = (tag_final == tag_exp_r);

  acorn128_step u_step (
    .s      (state),
    .m      (m),
    .ca     (ca),
    .cb     (cb),
    .s_next (state_nxt),
    .ks     (ks)
  );

  always_ff @(posedge clk) begin
    if (rst) phase <= IDLE;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    last_step = 1'b0;
    m         = 1'b0;
    ca        = 1'b1;
    cb        = 1'b1;
    case (phase)
      IDLE: if (start_in) phase_nxt = INIT;
      INIT: begin
        // key, then IV, then key repeated with a single domain bit flipped on its first bit
        m = ((cnt[CNT_W-1:IDX_W] == (CNT_W-IDX_W)'(1)) ? iv_r[idx] : key_r[idx])
            ^ (cnt == CNT_W'(KEY_IV_STEPS));
        last_step = (cnt == CNT_W'(INIT_STEPS - 1));
        if (last_step) phase_nxt = AD;
      end
      AD: begin
        m         = ad_r[idx];
        last_step = (cnt == CNT_W'(MSG_BITS - 1));
        if (last_step) phase_nxt = AD_PAD;
      end
      AD_PAD: begin
        m         = (cnt == '0);
        ca        = (cnt < CNT_W'(MSG_BITS));
        last_step = (cnt == CNT_W'(PAD_STEPS - 1));
        if (last_step) phase_nxt = CT;
      end
      CT: begin
        m         = p;
        cb        = 1'b0;
        last_step = (cnt == CNT_W'(MSG_BITS - 1));
        if (last_step) phase_nxt = CT_PAD;
      end
      CT_PAD: begin
        m         = (cnt == '0);
        ca        = (cnt < CNT_W'(MSG_BITS));
        cb        = 1'b0;
        last_step = (cnt == CNT_W'(PAD_STEPS - 1));
        if (last_step) phase_nxt = FINAL;
      end
      FINAL: begin
        last_step = (cnt == CNT_W'(FINAL_STEPS - 1));
        if (last_step) phase_nxt = DONE;
      end
      DONE:    phase_nxt = IDLE;
      default: phase_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || last_step || !stepping) cnt <= '0;
    else                               cnt <= cnt + CNT_W'(1);
  end

  // Results are registered on the last FINAL step so they are valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= '0;
      key_r         <= '0;
      iv_r          <= '0;
      ad_r          <= '0;
      ct_r          <= '0;
      tag_exp_r     <= '0;
      pt_sr         <= '0;
      tag_sr        <= '0;
      plaintext_out <= '0;
      tag_out       <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      auth_ok_out   <= 1'b0;
    end else if (accept) begin
      state         <= '0;
      key_r         <= key_in;
      iv_r          <= iv_in;
      ad_r          <= associated_data_in;
      ct_r          <= ciphertext_in;
      tag_exp_r     <= tag_in;
      pt_sr         <= '0;
      tag_sr        <= '0;
      plaintext_out <= '0;
      tag_out       <= '0;
      busy_out      <= 1'b1;
      done_out      <= 1'b0;
      auth_ok_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (stepping) state <= state_nxt;
      if (phase == CT) pt_sr <= {p, pt_sr[MSG_BITS-1:1]};
      if (phase == FINAL && cnt >= CNT_W'(TAG_START)) tag_sr <= {ks, tag_sr[MSG_BITS-2:1]};
      if (phase == FINAL && last_step) begin
        done_out    <= 1'b1;
        busy_out    <= 1'b0;
        tag_out     <= tag_final;
        auth_ok_out <= tag_match;
`ifdef ACORN_RELEASE_UNVERIFIED_EN
        plaintext_out <= pt_sr;
`else
        plaintext_out <= tag_match ? pt_sr : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_acorn128_decrypt.sv
// Self-checking bench for acorn128_decrypt against a bit-serial ACORN-128 reference model.
// Honours ACORN_RELEASE_UNVERIFIED_EN when predicting plaintext_out on authentication failure.
module tb_acorn128_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [127:0] key_in, iv_in, associated_data_in, ciphertext_in, tag_in;
  logic [127:0] plaintext_out, tag_out;
  logic         busy_out, done_out, auth_ok_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit [292:0] ms;

  localparam int LATENCY = 3329;

  acorn128_decrypt dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .key_in             (key_in),
    .iv_in              (iv_in),
    .associated_data_in (associated_data_in),
    .ciphertext_in      (ciphertext_in),
    .tag_in             (tag_in),
    .plaintext_out      (plaintext_out),
    .tag_out            (tag_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .auth_ok_out        (auth_ok_out)
  );

  always #5 clk = ~clk;

  function automatic bit [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit [127:0] gate(input bit [127:0] pt, input bit ok);
`ifdef ACORN_RELEASE_UNVERIFIED_EN
    return pt;
`else
    return ok ? pt : 128'h0;
`endif
  endfunction

  function automatic bit vote(input bit a, input bit b, input bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Reference: one cipher step on ms; m = m_base, or m_base ^ ks when add_ks is set (decryption).
  task automatic model_step(input bit m_base, input bit add_ks, input bit ca, input bit cb,
                            output bit k);
    bit [292:0] u;
    bit f;
    u = ms;
    u[290] = ms[290] ^ ms[235] ^ ms[230];
    u[228] = ms[228] ^ ms[196] ^ ms[193];
    u[192] = ms[192] ^ ms[160] ^ ms[154];
    u[153] = ms[153] ^ ms[111] ^ ms[107];
    u[106] = ms[106] ^ ms[66]  ^ ms[61];
    u[60]  = ms[60]  ^ ms[23]  ^ ms[0];
    k  = u[12] ^ u[154] ^ vote(u[235], u[61], u[193]) ^ (u[230] ? u[111] : u[66]);
    f  = u[0] ^ !u[107] ^ vote(u[244], u[23], u[160]) ^ (ca & u[196]) ^ (cb & k);
    ms = {f ^ m_base ^ (add_ks & k), u[292:1]};
  endtask

  // Whole ACORN-128 run; encrypt maps pt->ct, decrypt maps ct->pt; both produce the tag.
  task automatic model_run(input bit [127:0] key, input bit [127:0] iv, input bit [127:0] ad,
                           input bit [127:0] data, input bit decrypt,
                           output bit [127:0] out_d, output bit [127:0] tag);
    bit k, m;
    ms = '0;
    out_d = '0;
    tag = '0;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)      m = key[i];
      else if (i < 256) m = iv[i-128];
      else              m = key[i%128];
      if (i == 256) m = !m;
      model_step(m, 1'b0, 1'b1, 1'b1, k);
    end
    for (int i = 0; i < 128; i++) model_step(ad[i], 1'b0, 1'b1, 1'b1, k);
    for (int i = 0; i < 256; i++) model_step(i == 0, 1'b0, i < 128, 1'b1, k);
    for (int i = 0; i < 128; i++) begin
      model_step(data[i], decrypt, 1'b1, 1'b0, k);
      out_d[i] = data[i] ^ k;
    end
    for (int i = 0; i < 256; i++) model_step(i == 0, 1'b0, i < 128, 1'b0, k);
    for (int i = 0; i < 768; i++) begin
      model_step(1'b0, 1'b0, 1'b1, 1'b1, k);
      if (i >= 640) tag[i-640] = k;
    end
  endtask

  // Drives one decryption; cycles counts from the start_in cycle to the done_out cycle (bounded).
  task automatic run_dut(input bit [127:0] key, input bit [127:0] iv, input bit [127:0] ad,
                         input bit [127:0] ct, input bit [127:0] tag, input int disturb_at,
                         output bit [127:0] pt_o, output bit [127:0] tag_o, output bit auth_o,
                         output int cycles, output bit busy_ok);
    @(negedge clk);
    key_in = key; iv_in = iv; associated_data_in = ad; ciphertext_in = ct; tag_in = tag;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    cycles = 1;
    busy_ok = 1'b1;
    while (!done_out && cycles < 4000) begin
      if (busy_out !== 1'b1) busy_ok = 1'b0;
      if (cycles == disturb_at) begin
        start_in = 1'b1;
        key_in = rnd128(); iv_in = rnd128(); associated_data_in = rnd128();
        ciphertext_in = rnd128(); tag_in = rnd128();
      end else begin
        start_in = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start_in = 1'b0;
    if (busy_out !== 1'b0) busy_ok = 1'b0;
    pt_o = plaintext_out; tag_o = tag_out; auth_o = auth_ok_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b0;
    key_in = '0; iv_in = '0; associated_data_in = '0; ciphertext_in = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (plaintext_out !== '0) begin n_fail++; $display("[TB] FAIL reset_plaintext: got %h expected 0", plaintext_out); end
    n_checks++; if (tag_out !== '0) begin n_fail++; $display("[TB] FAIL reset_tag: got %h expected 0", tag_out); end
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_out); end
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done_out); end
    n_checks++; if (auth_ok_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_auth: got %b expected 0", auth_ok_out); end
    rst = 1'b0;
  endtask

  task automatic test_zero_roundtrip();
    bit [127:0] ct, tag, pt_o, tag_o;
    bit auth_o, busy_ok;
    int cyc;
    model_run('0, '0, '0, '0, 1'b0, ct, tag);
    run_dut('0, '0, '0, ct, tag, 0, pt_o, tag_o, auth_o, cyc, busy_ok);
    n_checks++; if (pt_o !== '0) begin n_fail++; $display("[TB] FAIL zero_plaintext: got %h expected 0", pt_o); end
    n_checks++; if (tag_o !== tag) begin n_fail++; $display("[TB] FAIL zero_tag: got %h expected %h", tag_o, tag); end
    n_checks++; if (auth_o !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_auth: got %b expected 1", auth_o); end
    n_checks++; if (cyc !== LATENCY) begin n_fail++; $display("[TB] FAIL zero_latency: got %0d expected %0d", cyc, LATENCY); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_busy: got %b expected 1", busy_ok); end
  endtask

  task automatic test_vector_roundtrip();
    bit [127:0] key, iv, ad, pt, ct, tag, pt_o, tag_o, bad;
    bit auth_o, busy_ok;
    int cyc;
    key = 128'h000102030405060708090A0B0C0D0E0F;
    iv  = 128'h0F0E0D0C0B0A09080706050403020100;
    pt  = {4{32'hDEADBEEF}};
    ad  = {16{8'hA5}};
    model_run(key, iv, ad, pt, 1'b0, ct, tag);
    run_dut(key, iv, ad, ct, tag, 0, pt_o, tag_o, auth_o, cyc, busy_ok);
    n_checks++; if (pt_o !== pt) begin n_fail++; $display("[TB] FAIL vec_plaintext: got %h expected %h", pt_o, pt); end
    n_checks++; if (tag_o !== tag) begin n_fail++; $display("[TB] FAIL vec_tag: got %h expected %h", tag_o, tag); end
    n_checks++; if (auth_o !== 1'b1) begin n_fail++; $display("[TB] FAIL vec_auth: got %b expected 1", auth_o); end
    n_checks++; if (cyc !== LATENCY) begin n_fail++; $display("[TB] FAIL vec_latency: got %0d expected %0d", cyc, LATENCY); end
    @(negedge clk);
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("[TB] FAIL vec_done_pulse: got %b expected 0", done_out); end
    n_checks++; if (auth_ok_out !== 1'b1) begin n_fail++; $display("[TB] FAIL vec_auth_hold: got %b expected 1", auth_ok_out); end

    bad = tag;
    bad[77] = !bad[77];
    run_dut(key, iv, ad, ct, bad, 0, pt_o, tag_o, auth_o, cyc, busy_ok);
    n_checks++; if (auth_o !== 1'b0) begin n_fail++; $display("[TB] FAIL tagflip_auth: got %b expected 0", auth_o); end
    n_checks++; if (pt_o !== gate(pt, 1'b0)) begin n_fail++; $display("[TB] FAIL tagflip_plaintext: got %h expected %h", pt_o, gate(pt, 1'b0)); end
    n_checks++; if (tag_o !== tag) begin n_fail++; $display("[TB] FAIL tagflip_tag: got %h expected %h", tag_o, tag); end
  endtask

  task automatic test_ct_flip();
    bit [127:0] key, iv, ad, pt, ct, tag, pt_o, tag_o, dpt, dtag;
    bit auth_o, busy_ok, exp_auth;
    int cyc;
    key = 128'h000102030405060708090A0B0C0D0E0F;
    iv  = 128'h0F0E0D0C0B0A09080706050403020100;
    pt  = {4{32'hDEADBEEF}};
    ad  = {16{8'hA5}};
    model_run(key, iv, ad, pt, 1'b0, ct, tag);
    ct[0] = !ct[0];
    model_run(key, iv, ad, ct, 1'b1, dpt, dtag);
    exp_auth = (dtag == tag);
    run_dut(key, iv, ad, ct, tag, 0, pt_o, tag_o, auth_o, cyc, busy_ok);
    n_checks++; if (auth_o !== exp_auth) begin n_fail++; $display("[TB] FAIL ctflip_auth: got %b expected %b", auth_o, exp_auth); end
    n_checks++; if (tag_o !== dtag) begin n_fail++; $display("[TB] FAIL ctflip_tag: got %h expected %h", tag_o, dtag); end
    n_checks++; if (pt_o !== gate(dpt, exp_auth)) begin n_fail++; $display("[TB] FAIL ctflip_plaintext: got %h expected %h", pt_o, gate(dpt, exp_auth)); end
    n_checks++; if (cyc !== LATENCY) begin n_fail++; $display("[TB] FAIL ctflip_latency: got %0d expected %0d", cyc, LATENCY); end
  endtask

  task automatic test_start_while_busy();
    bit [127:0] key, iv, ad, pt, ct, tag, pt_o, tag_o;
    bit auth_o, busy_ok;
    int cyc;
    key = rnd128(); iv = rnd128(); ad = rnd128(); pt = rnd128();
    model_run(key, iv, ad, pt, 1'b0, ct, tag);
    run_dut(key, iv, ad, ct, tag, 2200, pt_o, tag_o, auth_o, cyc, busy_ok);
    n_checks++; if (pt_o !== pt) begin n_fail++; $display("[TB] FAIL busystart_plaintext: got %h expected %h", pt_o, pt); end
    n_checks++; if (tag_o !== tag) begin n_fail++; $display("[TB] FAIL busystart_tag: got %h expected %h", tag_o, tag); end
    n_checks++; if (auth_o !== 1'b1) begin n_fail++; $display("[TB] FAIL busystart_auth: got %b expected 1", auth_o); end
    n_checks++; if (cyc !== LATENCY) begin n_fail++; $display("[TB] FAIL busystart_latency: got %0d expected %0d", cyc, LATENCY); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL busystart_busy: got %b expected 1", busy_ok); end
  endtask

  task automatic test_reset_in_final();
    bit [127:0] key, iv, ad, pt, ct, tag, pt_o, tag_o;
    bit auth_o, busy_ok, done_seen, idle_ok;
    int cyc;
    @(negedge clk);
    key_in = rnd128(); iv_in = rnd128(); associated_data_in = rnd128();
    ciphertext_in = rnd128(); tag_in = rnd128();
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    cyc = 1;
    done_seen = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_out) done_seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL rstfinal_early_done: got %b expected 0", done_seen); end
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rstfinal_busy: got %b expected 0", busy_out); end
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("[TB] FAIL rstfinal_done: got %b expected 0", done_out); end
    n_checks++; if ({plaintext_out, tag_out, auth_ok_out} !== '0) begin n_fail++; $display("[TB] FAIL rstfinal_outputs: got pt=%h tag=%h auth=%b expected 0", plaintext_out, tag_out, auth_ok_out); end
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy_out !== 1'b0 || done_out !== 1'b0) idle_ok = 1'b0;
    end
    n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rstfinal_idle: got %b expected 1", idle_ok); end
    key = rnd128(); iv = rnd128(); ad = rnd128(); pt = rnd128();
    model_run(key, iv, ad, pt, 1'b0, ct, tag);
    run_dut(key, iv, ad, ct, tag, 0, pt_o, tag_o, auth_o, cyc, busy_ok);
    n_checks++; if (pt_o !== pt) begin n_fail++; $display("[TB] FAIL rstfinal_rerun_plaintext: got %h expected %h", pt_o, pt); end
    n_checks++; if (tag_o !== tag) begin n_fail++; $display("[TB] FAIL rstfinal_rerun_tag: got %h expected %h", tag_o, tag); end
    n_checks++; if (auth_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rstfinal_rerun_auth: got %b expected 1", auth_o); end
    n_checks++; if (cyc !== LATENCY) begin n_fail++; $display("[TB] FAIL rstfinal_rerun_latency: got %0d expected %0d", cyc, LATENCY); end
  endtask

  task automatic test_random();
    bit [127:0] key, iv, ad, pt, ct, tag, tag_use, pt_o, tag_o;
    bit auth_o, busy_ok, exp_auth;
    int cyc;
    for (int r = 0; r < 3; r++) begin
      key = rnd128(); iv = rnd128(); ad = rnd128(); pt = rnd128();
      model_run(key, iv, ad, pt, 1'b0, ct, tag);
      tag_use  = (r == 2) ? rnd128() : tag;
      exp_auth = (tag_use == tag);
      run_dut(key, iv, ad, ct, tag_use, 0, pt_o, tag_o, auth_o, cyc, busy_ok);
      n_checks++; if (pt_o !== gate(pt, exp_auth)) begin n_fail++; $display("[TB] FAIL rand%0d_plaintext: got %h expected %h", r, pt_o, gate(pt, exp_auth)); end
      n_checks++; if (tag_o !== tag) begin n_fail++; $display("[TB] FAIL rand%0d_tag: got %h expected %h", r, tag_o, tag); end
      n_checks++; if (auth_o !== exp_auth) begin n_fail++; $display("[TB] FAIL rand%0d_auth: got %b expected %b", r, auth_o, exp_auth); end
      n_checks++; if (cyc !== LATENCY) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", r, cyc, LATENCY); end
    end
  endtask

  initial begin
    $display("[TB] acorn128_decrypt bench starting");
    test_reset();
    test_zero_roundtrip();
    test_vector_roundtrip();
    test_ct_flip();
    test_start_while_busy();
    test_reset_in_final();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
